// File: rtl/fir_sample_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Shared definitions for the FIR test-sample source: sample width,
//             default strobe divider, pattern mode encodings, controller state
//             encoding and the combinational pattern function.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_IN_W = 3;    // signed sample width fed to the FIR
    localparam int DIV_600K = 20;   // 12 MHz / 20 = 600 kHz sample rate
    localparam int NUM_W    = 8;    // burst length / sample index width

    typedef enum logic [1:0] {
        MODE_IMPULSE = 2'b00,
        MODE_STEP    = 2'b01,
        MODE_ALT     = 2'b10,
        MODE_RAMP    = 2'b11
    } fir_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    // Sample value for one index. Only the low bits of the index matter:
    // bit 0 gives the alternating parity, bits [2:0] are the ramp value.
    // phaseZero is true when the impulse period counter sits at 0.
    function automatic logic [FIR_IN_W-1:0] fnPattern(
        input fir_mode_e             mode,
        input logic [FIR_IN_W-1:0]   amp,
        input logic [FIR_IN_W-1:0]   nLow,
        input logic                  phaseZero
    );
        logic [FIR_IN_W-1:0] result;
        result = '0;
        case (mode)
            MODE_IMPULSE: result = phaseZero ? amp : '0;
            MODE_STEP:    result = amp;
            // Negation wraps in 3 bits, so -(-4) stays -4.
            MODE_ALT:     result = nLow[0] ? -amp : amp;
            MODE_RAMP:    result = nLow;
            default:      result = '0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sample_source_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_source_if
//  Purpose  : Control/sample bundle of the FIR test-sample source.
//  Signals  : iStart, iMode, iAmp, iPeriod, iNumSamples  (master -> source)
//             oEnSample_600kHz, oFirIn, oBusy, oDone      (source -> master)
//  Modports : master (controller / consumer side), slave (the source)
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_sample_source_if
    import fir_pkg::*;
#(
    parameter int P_PERIOD_W = 7
);
    logic                   iStart;
    logic [1:0]             iMode;
    logic [FIR_IN_W-1:0]    iAmp;
    logic [P_PERIOD_W-1:0]  iPeriod;
    logic [NUM_W-1:0]       iNumSamples;
    logic                   oEnSample_600kHz;
    logic [FIR_IN_W-1:0]    oFirIn;
    logic                   oBusy;
    logic                   oDone;

    modport master (
        output iStart, iMode, iAmp, iPeriod, iNumSamples,
        input  oEnSample_600kHz, oFirIn, oBusy, oDone
    );

    modport slave (
        input  iStart, iMode, iAmp, iPeriod, iNumSamples,
        output oEnSample_600kHz, oFirIn, oBusy, oDone
    );
endinterface
`default_nettype wire

// File: rtl/fir_sample_source_strobe_div.sv
`default_nettype none
// ============================================================================
//  Module   : fir_strobe_div
//  Purpose  : Clear-able modulo-P_DIV counter. A clear produces a strobe in
//             the following cycle; after that a strobe appears every P_DIV
//             cycles while iEnable is high at the wrap.
//  Ports    : iClk_12MHz - clock
//             iRst       - synchronous active-high reset
//             iClear     - restart the count, strobe next cycle
//             iEnable    - allow the strobe at the wrap point
//             oStrobe    - registered one-cycle strobe
//             oWrap      - count is at P_DIV-1 (next edge starts a new period)
//  Revision : 1.0 - initial release
// ============================================================================
module fir_strobe_div #(
    parameter int P_DIV = fir_pkg::DIV_600K
) (
    input  logic iClk_12MHz,
    input  logic iRst,
    input  logic iClear,
    input  logic iEnable,
    output logic oStrobe,
    output logic oWrap
);

    localparam int               CNT_W    = (P_DIV > 1) ? $clog2(P_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge iClk_12MHz) begin
        if (iRst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (iClear) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
        end else begin
            r_cnt    <= w_wrap ? '0 : r_cnt + CNT_ONE;
            r_strobe <= iEnable && w_wrap;
        end
    end

    assign oStrobe = r_strobe;
    assign oWrap   = w_wrap;

endmodule
`default_nettype wire

// File: rtl/fir_sample_source.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_source
//  Purpose  : Generates bursts of test samples (impulse, step, alternating,
//             ramp) for a FIR filter at one sample per P_DIV clocks.
//  Ports    : iClk_12MHz - system clock
//             iRst       - synchronous active-high reset
//             bus        - fir_sample_source_if.slave: start/mode/amplitude/
//                          period/length in; strobe, sample, busy, done out
//  Revision : 1.0 - initial release
// ============================================================================
module fir_sample_source
    import fir_pkg::*;
#(
    parameter int P_DIV      = DIV_600K,
    parameter int P_PERIOD_W = 7
) (
    input  logic              iClk_12MHz,
    input  logic              iRst,
    fir_sample_source_if.slave bus
);

    localparam logic [P_PERIOD_W-1:0] PER_ONE = P_PERIOD_W'(1);
    localparam logic [NUM_W-1:0]      NUM_ONE = NUM_W'(1);

    fir_state_e             r_state;
    fir_mode_e              r_mode;
    logic [FIR_IN_W-1:0]    r_amp;
    logic [P_PERIOD_W-1:0]  r_perLast;   // period-1, with period 0 folded to 1
    logic [NUM_W-1:0]       r_numLast;   // N-1; N=0 wraps to 255 meaning 256
    logic [NUM_W-1:0]       r_n;         // index of the sample currently shown
    logic [P_PERIOD_W-1:0]  r_perCnt;    // n mod period, kept incrementally
    logic [FIR_IN_W-1:0]    r_firIn;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_start;
    logic                   w_last;
    logic                   w_wrap;
    logic                   w_strobe;
    logic                   w_divEnable;
    logic [NUM_W-1:0]       w_nNext;
    logic [P_PERIOD_W-1:0]  w_perNext;
    fir_mode_e              w_inMode;

    assign w_inMode    = fir_mode_e'(bus.iMode);
    assign w_start     = (r_state == ST_IDLE) && bus.iStart;
    assign w_last      = (r_n == r_numLast);
    assign w_nNext     = r_n + NUM_ONE;
    assign w_perNext   = (r_perCnt == r_perLast) ? '0 : r_perCnt + PER_ONE;
    // Suppress the strobe that would follow the final sample period.
    assign w_divEnable = (r_state == ST_RUN) && !w_last;

    fir_strobe_div #(
        .P_DIV (P_DIV)
    ) u_div (
        .iClk_12MHz (iClk_12MHz),
        .iRst       (iRst),
        .iClear     (w_start),
        .iEnable    (w_divEnable),
        .oStrobe    (w_strobe),
        .oWrap      (w_wrap)
    );

    always_ff @(posedge iClk_12MHz) begin
        if (iRst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_IMPULSE;
            r_amp     <= '0;
            r_perLast <= '0;
            r_numLast <= '0;
            r_n       <= '0;
            r_perCnt  <= '0;
            r_firIn   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_firIn <= '0;
                    if (bus.iStart) begin
                        r_state   <= ST_RUN;
                        r_mode    <= w_inMode;
                        r_amp     <= bus.iAmp;
                        r_perLast <= (bus.iPeriod == '0) ? '0 : bus.iPeriod - PER_ONE;
                        r_numLast <= bus.iNumSamples - NUM_ONE;
                        r_n       <= '0;
                        r_perCnt  <= '0;
                        r_busy    <= 1'b1;
                        // Sample 0 goes out with the first strobe, so it is
                        // built from the live inputs rather than the captures.
                        r_firIn   <= fnPattern(w_inMode, bus.iAmp, '0, 1'b1);
                    end
                end

                ST_RUN: begin
                    if (w_wrap) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_n      <= w_nNext;
                            r_perCnt <= w_perNext;
                            r_firIn  <= fnPattern(r_mode, r_amp,
                                                  w_nNext[FIR_IN_W-1:0],
                                                  (w_perNext == '0));
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_firIn <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oEnSample_600kHz = w_strobe;
    assign bus.oFirIn           = r_firIn;
    assign bus.oBusy            = r_busy;
    assign bus.oDone            = r_done;

endmodule
`default_nettype wire

// File: doc/fir_sample_source.md
FIR_SAMPLE_SOURCE -- requirements
Module: fir_sample_source

Interface
REQ-001 Parameter P_DIV, default 20, SHALL set clocks per sample strobe (12 MHz / 20 = 600 kHz).
REQ-002 Parameter P_PERIOD_W, default 7, SHALL set the width of iPeriod.
REQ-003 iClk_12MHz  in  1  SHALL be the single system clock.
REQ-004 iRst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 iStart  in  1  SHALL request a burst; it is sampled only in IDLE.
REQ-006 iMode  in  2  SHALL select the pattern: 00 impulse, 01 step, 10 alternating, 11 ramp.
REQ-007 iAmp  in  3  SHALL carry the signed two's-complement amplitude.
REQ-008 iPeriod  in  P_PERIOD_W  SHALL set the impulse repetition period in samples; 0 is treated as 1.
REQ-009 iNumSamples  in  8  SHALL set the burst length in samples; 0 means 256.
REQ-010 oEnSample_600kHz  out  1  SHALL be a one-clock sample strobe.
REQ-011 oFirIn  out  3  SHALL carry the signed sample, valid on the strobe and held until the next strobe.
REQ-012 oBusy  out  1  SHALL be high while a burst is in progress.
REQ-013 oDone  out  1  SHALL pulse for one clock at burst end.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with iStart=1 at edge k, the block SHALL capture iMode, iAmp, iPeriod and iNumSamples, clear the sample index n and the divider, and enter RUN.
REQ-016 The first strobe SHALL be asserted in the cycle after edge k, carrying sample n=0.
REQ-017 Each subsequent strobe SHALL follow exactly P_DIV clocks after the previous one.
REQ-018 oFirIn SHALL update on the same edge that raises the strobe and SHALL be constant between strobes.
REQ-019 Impulse mode SHALL output iAmp when n mod period = 0, otherwise 0.
REQ-020 Step mode SHALL output iAmp for every n.
REQ-021 Alternating mode SHALL output iAmp for even n and -iAmp (3-bit wrap, so -(-4) = -4) for odd n.
REQ-022 Ramp mode SHALL output n[2:0] as a 3-bit value, wrapping 3 -> -4.
REQ-023 The period counter SHALL wrap to 0 at period-1, independently of n.
REQ-024 After strobe number N (n = N-1), the block SHALL wait P_DIV clocks, then enter DONE.
REQ-025 In DONE, oDone SHALL be 1 for exactly one clock, oBusy SHALL be 0, and the next state SHALL be IDLE.
REQ-026 oBusy SHALL be 1 from the first strobe cycle through the cycle before oDone.
REQ-027 iStart SHALL be ignored in RUN and DONE; iStart held high in IDLE SHALL start a new burst on the cycle after DONE.
REQ-028 Input changes during RUN SHALL have no effect, because the captured values are used.
REQ-029 In IDLE, oFirIn SHALL hold 0 and oEnSample_600kHz SHALL be 0.
REQ-030 The divider and index counters SHALL be exactly wide enough for P_DIV-1 and 255; no counter may overflow within a burst.

Reset
REQ-031 When iRst=1 at a clock edge, the FSM SHALL go to IDLE with oEnSample_600kHz=0, oFirIn=0, oBusy=0, oDone=0, and all counters and captured registers cleared.
REQ-032 Reset SHALL override iStart in the same cycle.
REQ-033 Reset mid-burst SHALL abort the burst with no oDone pulse; the first post-reset strobe SHALL occur only after a new iStart.

Structure
REQ-034 A shared package fir_pkg SHALL hold the mode encodings (MODE_IMPULSE, MODE_STEP, MODE_ALT, MODE_RAMP), the FSM state typedef, FIR_IN_W = 3 and DIV_600K = 20.
REQ-035 One sub-module, fir_strobe_div, SHALL be instantiated: a clear-able modulo-P_DIV counter that emits the strobe one cycle after clear and then every P_DIV cycles.
REQ-036 Pattern generation SHALL be combinational from the captured registers, n and the period count, and SHALL be registered into oFirIn.

Verification
REQ-037 Impulse: iMode=00, iAmp=001, iPeriod=64, iNumSamples=128 -> oFirIn=001 at n=0 and n=64, 000 elsewhere; strobes 20 clocks apart; oDone pulses 20 clocks after strobe 128.
REQ-038 Negative alternating: iMode=10, iAmp=100 (-4), N=4 -> samples 100,100,100,100; iAmp=111, N=4 -> 111,001,111,001.
REQ-039 Ramp wrap and N=0: iMode=11, iNumSamples=0 -> 256 strobes; samples cycle 000..111 repeatedly; exactly one oDone pulse.
REQ-040 Reset mid-burst: assert iRst at strobe 10 of 64 -> all outputs 0 on the next clock, no oDone, no strobe until a new iStart.
REQ-041 Start while busy and back-to-back: pulse iStart during RUN -> ignored; hold iStart high -> second burst's first strobe in the cycle after oDone's IDLE cycle.
REQ-042 Input change mid-burst: change iAmp from 001 to 011 during RUN -> burst keeps emitting 001 until oDone.
